// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the EXE-stage mul/div sequencer: RV64M funct3 codes,
// FSM state type and per-op decode helpers.
package cpu_pkg;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_WAIT,
      ST_DONE
   } md_state_e;

   function automatic logic op_is_div(input logic [2:0] op);
      return op[2];
   endfunction

   // High half (MULH*) or remainder (REM*) is the architectural result
   function automatic logic op_sel_hi(input logic [2:0] op);
      return (op != F3_MUL) && (op != F3_DIV) && (op != F3_DIVU);
   endfunction

   function automatic logic op_sgn_a(input logic [2:0] op);
      return (op != F3_MULHU) && (op != F3_DIVU) && (op != F3_REMU);
   endfunction

   function automatic logic op_sgn_b(input logic [2:0] op);
      return op_sgn_a(op) && (op != F3_MULHSU);
   endfunction

endpackage

// File: rtl/muldiv_special.sv
// Combinational front end: W-form operand extension plus divide-by-zero and
// signed-overflow detection with the architectural shortcut results.
module muldiv_special
   import cpu_pkg::*;
#(
   parameter int unsigned WIDTH = 64
) (
   input  logic [2:0]       op_i,
   input  logic             w_i,
   input  logic [WIDTH-1:0] src1_i,
   input  logic [WIDTH-1:0] src2_i,
   output logic [WIDTH-1:0] a_o,
   output logic [WIDTH-1:0] b_o,
   output logic             shortcut_o,
   output logic [WIDTH-1:0] sc_lo_o,
   output logic [WIDTH-1:0] sc_hi_o
);

   logic             sgn_a;
   logic             sgn_b;
   logic [WIDTH-1:0] int_min;
   logic             div_zero;
   logic             div_ovf;

   assign sgn_a = op_sgn_a(op_i);
   assign sgn_b = op_sgn_b(op_i);

   always_comb begin
      a_o = src1_i;
      b_o = src2_i;
      if (w_i) begin
         a_o = sgn_a ? {{(WIDTH-32){src1_i[31]}}, src1_i[31:0]} : {{(WIDTH-32){1'b0}}, src1_i[31:0]};
         b_o = sgn_b ? {{(WIDTH-32){src2_i[31]}}, src2_i[31:0]} : {{(WIDTH-32){1'b0}}, src2_i[31:0]};
      end
   end

   // Checking the extended operands covers both modes: the 32-bit INT_MIN and -1
   // appear here already sign-extended to full width.
   assign int_min  = w_i ? {{(WIDTH-31){1'b1}}, {31{1'b0}}} : {1'b1, {(WIDTH-1){1'b0}}};
   assign div_zero = (b_o == '0);
   assign div_ovf  = sgn_a && (a_o == int_min) && (b_o == '1);

   assign shortcut_o = op_is_div(op_i) && (div_zero || div_ovf);
   assign sc_lo_o    = div_zero ? '1  : a_o;
   assign sc_hi_o    = div_zero ? a_o : '0;

endmodule

// File: rtl/muldiv_sched.sv
// Sequencer for the shared iterative mul/div unit: accepts one RV64M op, shortcuts
// div-by-zero/overflow, otherwise drives the unit and holds the formatted result.
module muldiv_sched
   import cpu_pkg::*;
#(
   parameter int unsigned WIDTH      = 64,
   parameter int unsigned MAX_CYCLES = 80
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [2:0]       req_op,
   input  logic             req_32bit,
   input  logic [WIDTH-1:0] req_src1,
   input  logic [WIDTH-1:0] req_src2,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [WIDTH-1:0] resp_result,
   output logic             unit_start,
   output logic             unit_is_div,
   output logic             unit_sgn_a,
   output logic             unit_sgn_b,
   output logic [WIDTH-1:0] unit_a,
   output logic [WIDTH-1:0] unit_b,
   output logic             unit_flush,
   input  logic             unit_done,
   input  logic [WIDTH-1:0] unit_lo,
   input  logic [WIDTH-1:0] unit_hi,
   output logic             wdog_err
);

   localparam int unsigned CW = $clog2(MAX_CYCLES + 1);

   md_state_e        state_q;
   logic [2:0]       op_q;
   logic             w_q;
   logic [CW-1:0]    cnt_q;
   logic             unit_start_q;
   logic             unit_flush_q;
   logic             unit_is_div_q;
   logic             unit_sgn_a_q;
   logic             unit_sgn_b_q;
   logic [WIDTH-1:0] unit_a_q;
   logic [WIDTH-1:0] unit_b_q;
   logic [WIDTH-1:0] result_q;
   logic             wdog_err_q;

   logic [WIDTH-1:0] ext_a;
   logic [WIDTH-1:0] ext_b;
   logic             shortcut;
   logic [WIDTH-1:0] sc_lo;
   logic [WIDTH-1:0] sc_hi;

   muldiv_special #(
      .WIDTH (WIDTH)
   ) u_special (
      .op_i       (req_op),
      .w_i        (req_32bit),
      .src1_i     (req_src1),
      .src2_i     (req_src2),
      .a_o        (ext_a),
      .b_o        (ext_b),
      .shortcut_o (shortcut),
      .sc_lo_o    (sc_lo),
      .sc_hi_o    (sc_hi)
   );

   function automatic logic [WIDTH-1:0] fmt_result(input logic [2:0] op, input logic w,
                                                   input logic [WIDTH-1:0] lo, input logic [WIDTH-1:0] hi);
      logic [WIDTH-1:0] r;
      r = op_sel_hi(op) ? hi : lo;
      if (w) r = {{(WIDTH-32){r[31]}}, r[31:0]};
      return r;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         op_q          <= '0;
         w_q           <= 1'b0;
         cnt_q         <= '0;
         unit_start_q  <= 1'b0;
         unit_flush_q  <= 1'b0;
         unit_is_div_q <= 1'b0;
         unit_sgn_a_q  <= 1'b0;
         unit_sgn_b_q  <= 1'b0;
         unit_a_q      <= '0;
         unit_b_q      <= '0;
         result_q      <= '0;
         wdog_err_q    <= 1'b0;
      end else begin
         unit_start_q <= 1'b0;
         unit_flush_q <= 1'b0;
         if (flush) begin
            if ((state_q == ST_START) || (state_q == ST_WAIT)) unit_flush_q <= 1'b1;
            state_q <= ST_IDLE;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (req_valid) begin
                     op_q <= req_op;
                     w_q  <= req_32bit;
                     if (shortcut) begin
                        result_q <= fmt_result(req_op, req_32bit, sc_lo, sc_hi);
                        state_q  <= ST_DONE;
                     end else begin
                        unit_is_div_q <= op_is_div(req_op);
                        unit_sgn_a_q  <= op_sgn_a(req_op);
                        unit_sgn_b_q  <= op_sgn_b(req_op);
                        unit_a_q      <= ext_a;
                        unit_b_q      <= ext_b;
                        unit_start_q  <= 1'b1;
                        state_q       <= ST_START;
                     end
                  end
               end
               ST_START: begin
                  cnt_q   <= '0;
                  state_q <= ST_WAIT;
               end
               ST_WAIT: begin
                  // Expiry fires on the cycle the count would step to MAX_CYCLES
                  if (unit_done) begin
                     result_q <= fmt_result(op_q, w_q, unit_lo, unit_hi);
                     state_q  <= ST_DONE;
                  end else if (cnt_q == CW'(MAX_CYCLES - 1)) begin
                     wdog_err_q   <= 1'b1;
                     unit_flush_q <= 1'b1;
                     state_q      <= ST_IDLE;
                  end else begin
                     cnt_q <= cnt_q + CW'(1);
                  end
               end
               ST_DONE: begin
                  if (resp_ready) state_q <= ST_IDLE;
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   assign req_ready   = (state_q == ST_IDLE) && !flush;
   assign resp_valid  = (state_q == ST_DONE) && !flush;
   assign resp_result = result_q;
   assign unit_start  = unit_start_q;
   assign unit_flush  = unit_flush_q;
   assign unit_is_div = unit_is_div_q;
   assign unit_sgn_a  = unit_sgn_a_q;
   assign unit_sgn_b  = unit_sgn_b_q;
   assign unit_a      = unit_a_q;
   assign unit_b      = unit_b_q;
   assign wdog_err    = wdog_err_q;

endmodule

// File: tb/tb_muldiv_sched.sv
// Self-checking bench for muldiv_sched: directed vector table, randomized ops against
// an RV64M arithmetic reference, and flush / watchdog / reset sequences.
module tb_muldiv_sched;

   localparam int unsigned MAXC = 80;
   localparam logic [2:0] OP_MUL = 3'd0, OP_MULH = 3'd1, OP_MULHSU = 3'd2, OP_MULHU = 3'd3;
   localparam logic [2:0] OP_DIV = 3'd4, OP_DIVU = 3'd5, OP_REM = 3'd6, OP_REMU = 3'd7;

   logic        clk = 1'b0;
   logic        rst, flush, req_valid, req_ready, req_32bit, resp_valid, resp_ready;
   logic        unit_start, unit_is_div, unit_sgn_a, unit_sgn_b, unit_flush, unit_done, wdog_err;
   logic [2:0]  req_op;
   logic [63:0] req_src1, req_src2, resp_result, unit_a, unit_b, unit_lo, unit_hi;

   int unsigned n_chk = 0;
   int unsigned n_err = 0;

   always #5 clk = ~clk;

   muldiv_sched #(.WIDTH(64), .MAX_CYCLES(MAXC)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_32bit(req_32bit),
      .req_src1(req_src1), .req_src2(req_src2),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
      .unit_start(unit_start), .unit_is_div(unit_is_div), .unit_sgn_a(unit_sgn_a), .unit_sgn_b(unit_sgn_b),
      .unit_a(unit_a), .unit_b(unit_b), .unit_flush(unit_flush),
      .unit_done(unit_done), .unit_lo(unit_lo), .unit_hi(unit_hi), .wdog_err(wdog_err)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
      end
   endtask

   task automatic fail_bound(input string name);
      n_chk++;
      n_err++;
      $display("FAIL %s: cycle bound expired without response", name);
   endtask

   // RV64M architectural result computed directly from the request
   function automatic logic [63:0] ref_res(input logic [2:0] op, input logic w, input logic [63:0] s1, input logic [63:0] s2);
      logic [127:0] p;
      logic [63:0]  r;
      logic [31:0]  a32, b32;
      longint       sa, sb;
      r = '0;
      if (w) begin
         a32 = s1[31:0];
         b32 = s2[31:0];
         sa  = longint'($signed(a32));
         sb  = longint'($signed(b32));
         case (op)
            OP_MUL:  r = 64'(sa * sb);
            OP_DIV:  r = (b32 == 0) ? '1 : 64'(sa / sb);
            OP_DIVU: r = (b32 == 0) ? '1 : {32'd0, a32 / b32};
            OP_REM:  r = (b32 == 0) ? 64'(sa) : 64'(sa % sb);
            OP_REMU: r = (b32 == 0) ? {32'd0, a32} : {32'd0, a32 % b32};
            default: r = '0;
         endcase
         r = {{32{r[31]}}, r[31:0]};
      end else begin
         sa = $signed(s1);
         sb = $signed(s2);
         case (op)
            OP_MUL:    begin p = {64'd0, s1} * {64'd0, s2}; r = p[63:0]; end
            OP_MULH:   begin p = {{64{s1[63]}}, s1} * {{64{s2[63]}}, s2}; r = p[127:64]; end
            OP_MULHSU: begin p = {{64{s1[63]}}, s1} * {64'd0, s2}; r = p[127:64]; end
            OP_MULHU:  begin p = {64'd0, s1} * {64'd0, s2}; r = p[127:64]; end
            OP_DIV:    r = (s2 == 0) ? '1 : (s1 == 64'h8000_0000_0000_0000 && s2 == '1) ? s1 : 64'(sa / sb);
            OP_DIVU:   r = (s2 == 0) ? '1 : s1 / s2;
            OP_REM:    r = (s2 == 0) ? s1 : (s1 == 64'h8000_0000_0000_0000 && s2 == '1) ? '0 : 64'(sa % sb);
            default:   r = (s2 == 0) ? s1 : s1 % s2;
         endcase
      end
      return r;
   endfunction

   function automatic logic ref_sc(input logic [2:0] op, input logic w, input logic [63:0] s1, input logic [63:0] s2);
      logic sgn;
      sgn = (op == OP_DIV) || (op == OP_REM);
      if (!op[2]) return 1'b0;
      if (w) return (s2[31:0] == 0) || (sgn && s1[31:0] == 32'h8000_0000 && s2[31:0] == 32'hFFFF_FFFF);
      return (s2 == 0) || (sgn && s1 == 64'h8000_0000_0000_0000 && s2 == '1);
   endfunction

   // Behaviour of the external iterative unit on whatever operands it is handed
   function automatic void unit_model(input logic [63:0] a, input logic [63:0] b, input logic d,
                                      input logic sa, input logic sb, output logic [63:0] lo, output logic [63:0] hi);
      logic [127:0] pa, pb, p;
      if (!d) begin
         pa = sa ? {{64{a[63]}}, a} : {64'd0, a};
         pb = sb ? {{64{b[63]}}, b} : {64'd0, b};
         p  = pa * pb;
         lo = p[63:0];
         hi = p[127:64];
      end else if (b == 0) begin
         lo = '1; hi = a;
      end else if (sa && a == 64'h8000_0000_0000_0000 && b == '1) begin
         lo = a; hi = '0;
      end else if (sa) begin
         lo = 64'($signed(a) / $signed(b));
         hi = 64'($signed(a) % $signed(b));
      end else begin
         lo = a / b; hi = a % b;
      end
   endfunction

   // Entered and left just after a rising edge; the scheduler must be idle.
   task automatic run_op(input string tag, input logic [2:0] op, input logic w, input logic [63:0] s1,
                         input logic [63:0] s2, input int unsigned lat, input logic exp_sc,
                         input logic [63:0] exp, input int unsigned hold);
      int unsigned cyc, start_cyc, resp_cyc, nstart, done_at;
      logic        got, started, held_ok, stable_ok;
      logic [63:0] ca, cb, res, lo, hi;
      logic        cdiv, csa, csb;
      req_op = op; req_32bit = w; req_src1 = s1; req_src2 = s2; req_valid = 1'b1;
      @(negedge clk);
      chk({tag, " accept"}, req_ready, 1);
      @(posedge clk); #1;
      req_valid = 1'b0; req_src1 = ~s1; req_src2 = ~s2;
      cyc = 1; got = 0; started = 0; nstart = 0; held_ok = 1; done_at = 0; start_cyc = 0; resp_cyc = 0;
      ca = '0; cb = '0; cdiv = 0; csa = 0; csb = 0; res = '0;
      while (!got && cyc < 200) begin
         unit_done = started && (cyc == done_at);
         if (unit_done) begin
            unit_model(ca, cb, cdiv, csa, csb, lo, hi);
            unit_lo = lo; unit_hi = hi;
         end else begin
            unit_lo = {$urandom, $urandom}; unit_hi = {$urandom, $urandom};
         end
         @(negedge clk);
         if (unit_start) begin
            nstart++;
            if (!started) begin
               started = 1; start_cyc = cyc; done_at = cyc + lat;
               ca = unit_a; cb = unit_b; cdiv = unit_is_div; csa = unit_sgn_a; csb = unit_sgn_b;
            end
         end else if (started && (unit_a !== ca || unit_b !== cb)) begin
            held_ok = 0;
         end
         if (resp_valid) begin got = 1; resp_cyc = cyc; res = resp_result; end
         @(posedge clk); #1;
         cyc++;
      end
      unit_done = 1'b0;
      if (!got) begin
         fail_bound({tag, " response"});
      end else begin
         chk({tag, " result"}, res, exp);
         chk({tag, " resp latency"}, 64'(resp_cyc), exp_sc ? 64'd1 : 64'(lat + 2));
         chk({tag, " unit_start count"}, 64'(nstart), exp_sc ? 64'd0 : 64'd1);
         chk({tag, " unit_start cycle"}, 64'(start_cyc), exp_sc ? 64'd0 : 64'd1);
         chk({tag, " operands held"}, 64'(held_ok), 64'd1);
         stable_ok = 1;
         for (int i = 0; i < int'(hold); i++) begin
            @(negedge clk);
            if (resp_valid !== 1'b1 || resp_result !== exp) stable_ok = 0;
            @(posedge clk); #1;
         end
         if (hold > 0) chk({tag, " held result stable"}, 64'(stable_ok), 64'd1);
         resp_ready = 1'b1;
         @(negedge clk);
         chk({tag, " valid at handshake"}, resp_valid, 1);
         chk({tag, " no accept in DONE"}, req_ready, 0);
         @(posedge clk); #1;
         resp_ready = 1'b0;
         @(negedge clk);
         chk({tag, " idle after handshake"}, {resp_valid, req_ready}, 2'b01);
         @(posedge clk); #1;
      end
   endtask

   function automatic logic [63:0] pick();
      case ($urandom_range(0, 7))
         0:       return '0;
         1:       return '1;
         2:       return 64'd1;
         3:       return 64'h8000_0000_0000_0000;
         4:       return 64'h0000_0000_8000_0000;
         5:       return 64'hFFFF_FFFF_0000_0000;
         6:       return 64'($urandom_range(0, 20));
         default: return {$urandom, $urandom};
      endcase
   endfunction

   typedef struct {
      logic [2:0]  op;
      logic        w;
      logic [63:0] s1;
      logic [63:0] s2;
      int unsigned lat;
      int unsigned hold;
      logic        sc;
      logic [63:0] exp;
   } vec_t;

   vec_t        tbl[15];
   int unsigned cnt_a, cnt_b, cnt_c, wcyc;

   initial begin
      tbl[0]  = '{OP_DIVU,   1'b0, 64'd100, 64'd7, 64, 0, 1'b0, 64'd14};
      tbl[1]  = '{OP_REMU,   1'b0, 64'd100, 64'd7, 5,  5, 1'b0, 64'd2};
      tbl[2]  = '{OP_DIV,    1'b0, 64'd5, 64'd0, 1, 0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF};
      tbl[3]  = '{OP_REM,    1'b0, 64'd5, 64'd0, 1, 2, 1'b1, 64'd5};
      tbl[4]  = '{OP_DIV,    1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 1'b1, 64'hFFFF_FFFF_8000_0000};
      tbl[5]  = '{OP_REM,    1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 1'b1, 64'd0};
      tbl[6]  = '{OP_MULH,   1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 3, 0, 1'b0, 64'd0};
      tbl[7]  = '{OP_MUL,    1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 4, 0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE};
      tbl[8]  = '{OP_DIV,    1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 1'b1, 64'h8000_0000_0000_0000};
      tbl[9]  = '{OP_MULHU,  1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 6, 0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE};
      tbl[10] = '{OP_MULHSU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 2, 0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF};
      tbl[11] = '{OP_DIVU,   1'b1, 64'd5, 64'h0000_0001_0000_0000, 1, 0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF};
      tbl[12] = '{OP_DIV,    1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 7, 0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD};
      tbl[13] = '{OP_REM,    1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 2, 0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF};
      tbl[14] = '{OP_DIVU,   1'b1, 64'hFFFF_FFFF_FFFF_FFF0, 64'd16, 9, 0, 1'b0, 64'h0000_0000_0FFF_FFFF};

      rst = 1'b1; flush = 1'b0; req_valid = 1'b0; req_op = '0; req_32bit = 1'b0;
      req_src1 = '0; req_src2 = '0; resp_ready = 1'b0; unit_done = 1'b0; unit_lo = '0; unit_hi = '0;
      @(negedge clk);
      chk("reset ready", req_ready, 1);
      chk("reset flags", {resp_valid, unit_start, unit_flush, unit_is_div, unit_sgn_a, unit_sgn_b, wdog_err}, '0);
      chk("reset result", resp_result, '0);
      chk("reset unit_a|unit_b", unit_a | unit_b, '0);
      @(posedge clk); #1;
      rst = 1'b0;

      for (int i = 0; i < 15; i++)
         run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].w, tbl[i].s1, tbl[i].s2,
                tbl[i].lat, tbl[i].sc, tbl[i].exp, tbl[i].hold);

      for (int i = 0; i < 60; i++) begin
         logic [2:0]  op;
         logic        w;
         logic [63:0] s1, s2;
         op = 3'($urandom_range(0, 7));
         w  = 1'($urandom_range(0, 1));
         if (!op[2] && op != OP_MUL) w = 1'b0;
         s1 = pick(); s2 = pick();
         run_op($sformatf("rnd%0d op%0d w%0d", i, op, w), op, w, s1, s2, $urandom_range(1, 12),
                ref_sc(op, w, s1, s2), ref_res(op, w, s1, s2), $urandom_range(0, 2));
      end

      // flush in WAIT together with unit_done
      req_op = OP_DIVU; req_32bit = 1'b0; req_src1 = 64'd100; req_src2 = 64'd7; req_valid = 1'b1;
      @(negedge clk); chk("fw accept", req_ready, 1);
      @(posedge clk); #1; req_valid = 1'b0;
      @(negedge clk); chk("fw unit_start", unit_start, 1);
      @(posedge clk); #1; flush = 1'b1; unit_done = 1'b1; unit_lo = 64'd14; unit_hi = 64'd2;
      @(negedge clk);
      chk("fw flush cycle valid/ready", {resp_valid, req_ready}, 2'b00);
      cnt_a = unit_flush;
      @(posedge clk); #1; flush = 1'b0; unit_done = 1'b0;
      @(negedge clk);
      cnt_a += unit_flush;
      chk("fw ready after flush", req_ready, 1);
      chk("fw unit_flush pulses", 64'(cnt_a), 1);
      cnt_b = 0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1; @(negedge clk);
         cnt_b += resp_valid + unit_start + unit_flush;
      end
      chk("fw no response after flush", 64'(cnt_b), 0);
      @(posedge clk); #1;

      // request coinciding with flush is ignored
      req_op = OP_MUL; req_src1 = 64'd3; req_src2 = 64'd5; req_valid = 1'b1; flush = 1'b1;
      @(negedge clk); chk("flush blocks ready", req_ready, 0);
      @(posedge clk); #1; req_valid = 1'b0; flush = 1'b0;
      cnt_b = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); cnt_b += resp_valid + unit_start;
         @(posedge clk); #1;
      end
      chk("flushed request not taken", 64'(cnt_b), 0);

      // flush while holding a result in DONE
      req_op = OP_DIV; req_src1 = 64'd5; req_src2 = 64'd0; req_valid = 1'b1;
      @(posedge clk); #1; req_valid = 1'b0;
      @(negedge clk); chk("fd valid before flush", resp_valid, 1);
      @(posedge clk); #1; flush = 1'b1; resp_ready = 1'b1;
      @(negedge clk); chk("fd valid masked by flush", resp_valid, 0);
      @(posedge clk); #1; flush = 1'b0; resp_ready = 1'b0;
      @(negedge clk); chk("fd idle after flush", {resp_valid, req_ready}, 2'b01);
      @(posedge clk); #1;

      // watchdog: unit never answers
      req_op = OP_MUL; req_src1 = 64'd3; req_src2 = 64'd5; req_valid = 1'b1;
      @(posedge clk); #1; req_valid = 1'b0;
      cnt_a = 0; cnt_b = 0; cnt_c = 0; wcyc = 0;
      for (int c = 1; c <= int'(MAXC) + 10; c++) begin
         @(negedge clk);
         cnt_a += unit_flush; cnt_b += resp_valid; cnt_c += unit_start;
         if (wdog_err && wcyc == 0) wcyc = c;
         @(posedge clk); #1;
      end
      chk("wdog expiry near MAX_CYCLES", 64'((wcyc >= MAXC + 1) && (wcyc <= MAXC + 2)), 1);
      chk("wdog unit_flush pulses", 64'(cnt_a), 1);
      chk("wdog no response", 64'(cnt_b), 0);
      chk("wdog single start", 64'(cnt_c), 1);
      @(negedge clk); chk("wdog back to idle", req_ready, 1);
      @(posedge clk); #1;
      run_op("after wdog", OP_MULHU, 1'b0, 64'h1_0000_0000, 64'h1_0000_0000, 3, 1'b0, 64'd1, 0);
      @(negedge clk); chk("wdog_err sticky", wdog_err, 1);
      @(posedge clk); #1;

      // async reset mid-WAIT
      req_op = OP_DIV; req_src1 = 64'd77; req_src2 = 64'd3; req_valid = 1'b1;
      @(posedge clk); #1; req_valid = 1'b0;
      @(posedge clk); #1; @(posedge clk); #1;
      rst = 1'b1; #1;
      chk("rst mid-WAIT ready", req_ready, 1);
      chk("rst mid-WAIT flags", {resp_valid, unit_start, unit_flush, unit_is_div, unit_sgn_a, unit_sgn_b, wdog_err}, '0);
      chk("rst mid-WAIT result", resp_result, '0);
      chk("rst mid-WAIT operands", unit_a | unit_b, '0);
      @(posedge clk); #1; rst = 1'b0;
      run_op("after rst", OP_DIV, 1'b0, 64'd77, 64'd3, 4, 1'b0, 64'd25, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
